// File: rtl/medidor_faixa_uc_if.sv
// Control/status bundle between the range-measurement control unit and its datapath.
// master = control unit (drives commands), slave = datapath side (drives status).
`timescale 1ns/1ps
interface medidor_faixa_uc_if;
  logic       iniciar;
  logic       pronto_medida;
  logic       pronto_tx;
  logic       is_ultimo_char;
  logic       fim_time;
  logic       fim_3sec;
  logic       zera;
  logic       zera_char;
  logic       zera_time;
  logic       mensurar;
  logic       partida_tx;
  logic       conta_prox_char;
  logic       conta_time;
  logic       pronto;
  logic       db_timeout;
  logic [3:0] db_estado;

  modport master (
    input  iniciar, pronto_medida, pronto_tx, is_ultimo_char, fim_time, fim_3sec,
    output zera, zera_char, zera_time, mensurar, partida_tx, conta_prox_char,
           conta_time, pronto, db_timeout, db_estado
  );

  modport slave (
    output iniciar, pronto_medida, pronto_tx, is_ultimo_char, fim_time, fim_3sec,
    input  zera, zera_char, zera_time, mensurar, partida_tx, conta_prox_char,
           conta_time, pronto, db_timeout, db_estado
  );
endinterface

// File: rtl/medidor_faixa_uc.sv
// Moore control unit: measure, send "XYZ#" frame, wait interval, repeat until in-range hold.
// iniciar->mensurar 2 cycles, pronto_medida->partida_tx 1, pronto_tx->next partida_tx 2; stalls on pronto_* inputs.
`timescale 1ns/1ps
module medidor_faixa_uc #(
  parameter int TIMEOUT_M = 2_000_000,
  parameter int TIMEOUT_N = 21
) (
  input logic                clock,
  input logic                reset,
  medidor_faixa_uc_if.master bus
);

  typedef enum logic [3:0] {
    inicial          = 4'd0,
    preparacao       = 4'd1,
    medir            = 4'd2,
    aguarda_medida   = 4'd3,
    transmite        = 4'd4,
    espera_tx        = 4'd5,
    proximo_char     = 4'd6,
    espera_intervalo = 4'd7,
    acertou          = 4'd8
  } estado_t;

  localparam logic [TIMEOUT_N-1:0] WD_LIMITE = TIMEOUT_N'(TIMEOUT_M - 1);

  estado_t              estado;
  estado_t              estado_nxt;
  logic [TIMEOUT_N-1:0] watchdog;
  logic                 wd_fim;
  logic                 acerto;
  logic                 db_timeout;
  logic                 expira;
  logic                 em_medicao;

  logic zera, zera_char, zera_time, mensurar, partida_tx;
  logic conta_prox_char, conta_time, pronto;

  // A measurement arriving on the expiry cycle still counts as valid.
  assign expira     = (estado == aguarda_medida) && wd_fim && !bus.pronto_medida;
  assign em_medicao = (estado >= medir) && (estado <= espera_intervalo);

  always_ff @(posedge clock) begin
    if (reset) begin
      estado     <= inicial;
      watchdog   <= '0;
      wd_fim     <= 1'b0;
      acerto     <= 1'b0;
      db_timeout <= 1'b0;
    end else begin
      estado     <= estado_nxt;
      db_timeout <= expira;
      if (estado == medir) begin
        watchdog <= '0;
        wd_fim   <= 1'b0;
      end else if (estado == aguarda_medida) begin
        watchdog <= watchdog + TIMEOUT_N'(1);
        wd_fim   <= (watchdog == WD_LIMITE);
      end
      // fim_3sec is a single-cycle pulse; latch it so a busy frame cannot drop it.
      if (estado == preparacao) begin
        acerto <= 1'b0;
      end else if (bus.fim_3sec && em_medicao) begin
        acerto <= 1'b1;
      end
    end
  end

  always_comb begin
    estado_nxt      = estado;
    zera            = 1'b0;
    zera_char       = 1'b0;
    zera_time       = 1'b0;
    mensurar        = 1'b0;
    partida_tx      = 1'b0;
    conta_prox_char = 1'b0;
    conta_time      = 1'b0;
    pronto          = 1'b0;
    case (estado)
      inicial: begin
        if (bus.iniciar) estado_nxt = preparacao;
      end
      preparacao: begin
        zera       = 1'b1;
        zera_char  = 1'b1;
        zera_time  = 1'b1;
        estado_nxt = medir;
      end
      medir: begin
        mensurar   = 1'b1;
        zera_time  = 1'b1;
        estado_nxt = aguarda_medida;
      end
      aguarda_medida: begin
        if (bus.pronto_medida) estado_nxt = transmite;
        else if (wd_fim)       estado_nxt = medir;
      end
      transmite: begin
        partida_tx = 1'b1;
        estado_nxt = espera_tx;
      end
      espera_tx: begin
        if (bus.pronto_tx) estado_nxt = proximo_char;
      end
      proximo_char: begin
        conta_prox_char = 1'b1;
        estado_nxt      = bus.is_ultimo_char ? espera_intervalo : transmite;
      end
      // Only place the run can end, so a started frame always finishes.
      espera_intervalo: begin
        conta_time = 1'b1;
        if (acerto)            estado_nxt = acertou;
        else if (bus.fim_time) estado_nxt = medir;
      end
      acertou: begin
        pronto = 1'b1;
        if (bus.iniciar) estado_nxt = preparacao;
      end
      default: estado_nxt = inicial;
    endcase
  end

  assign bus.zera            = zera;
  assign bus.zera_char       = zera_char;
  assign bus.zera_time       = zera_time;
  assign bus.mensurar        = mensurar;
  assign bus.partida_tx      = partida_tx;
  assign bus.conta_prox_char = conta_prox_char;
  assign bus.conta_time      = conta_time;
  assign bus.pronto          = pronto;
  assign bus.db_timeout      = db_timeout;
  assign bus.db_estado       = estado;

endmodule

// File: tb/tb_medidor_faixa_uc.sv
// Directed bench for medidor_faixa_uc with a small datapath model (char counter, tx and sensor responders).
`timescale 1ns/1ps
module tb_medidor_faixa_uc;
  logic clock = 1'b0;
  logic reset = 1'b1;
  medidor_faixa_uc_if mif ();

  medidor_faixa_uc #(.TIMEOUT_M(100), .TIMEOUT_N(21)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (mif)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_tx = 0, n_cp = 0, n_mens = 0, n_tmo = 0;
  bit pm_auto = 1'b1;
  logic [1:0] cnt = 2'd0;

  // Datapath char counter: mod-4, cleared by zera_char.
  always @(posedge clock) begin
    if (mif.zera_char)            cnt <= 2'd0;
    else if (mif.conta_prox_char) cnt <= cnt + 2'd1;
  end
  assign mif.is_ultimo_char = (cnt == 2'd3);

  initial begin
    mif.pronto_medida = 1'b0;
    forever begin
      @(negedge clock);
      if (mif.mensurar && pm_auto) begin
        repeat (50) @(negedge clock);
        mif.pronto_medida = 1'b1;
        @(negedge clock);
        mif.pronto_medida = 1'b0;
      end
    end
  end

  initial begin
    mif.pronto_tx = 1'b0;
    forever begin
      @(negedge clock);
      if (mif.partida_tx) begin
        repeat (10) @(negedge clock);
        mif.pronto_tx = 1'b1;
        @(negedge clock);
        mif.pronto_tx = 1'b0;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout cyc=%0d", cyc);
    $fatal(1, "simulation time limit");
  end

  function automatic logic [8:0] outs();
    return {mif.zera, mif.zera_char, mif.zera_time, mif.mensurar, mif.partida_tx,
            mif.conta_prox_char, mif.conta_time, mif.pronto, mif.db_timeout};
  endfunction

  task automatic tick();
    @(negedge clock);
    #1;
    cyc++;
    if (mif.partida_tx)      n_tx++;
    if (mif.conta_prox_char) n_cp++;
    if (mif.mensurar)        n_mens++;
    if (mif.db_timeout)      n_tmo++;
  endtask

  task automatic wait_state(input logic [3:0] code, input int chr, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (mif.db_estado == code && (chr < 0 || int'(cnt) == chr)) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    bit idle_ok;
    mif.iniciar = 1'b0; mif.fim_time = 1'b0; mif.fim_3sec = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if (mif.db_estado !== 4'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", mif.db_estado); end
    checks++;
    if (outs() !== 9'b0) begin errors++; $display("FAIL reset_outputs got=%b exp=000000000", outs()); end
    reset = 1'b0;
    idle_ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (mif.db_estado !== 4'd0 || outs() !== 9'b0) idle_ok = 1'b0;
    end
    checks++;
    if (!idle_ok) begin errors++; $display("FAIL idle_20 got=state%0d/%b exp=state0/all0", mif.db_estado, outs()); end
  endtask

  task automatic test_frame();
    int tx0, cp0;
    bit ok;
    tx0 = n_tx; cp0 = n_cp;
    mif.iniciar = 1'b1;
    tick();
    mif.iniciar = 1'b0;
    checks++;
    if (mif.db_estado !== 4'd1 || {mif.zera, mif.zera_char, mif.zera_time} !== 3'b111) begin
      errors++; $display("FAIL prep_pulse got=state%0d zeras=%b exp=state1 zeras=111", mif.db_estado,
                         {mif.zera, mif.zera_char, mif.zera_time});
    end
    tick();
    checks++;
    if (mif.mensurar !== 1'b1) begin errors++; $display("FAIL iniciar_to_mensurar got=%b exp=1", mif.mensurar); end
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (mif.pronto_medida === 1'b1) begin ok = 1'b1; break; end
      tick();
    end
    tick();
    checks++;
    if (!ok || mif.partida_tx !== 1'b1) begin errors++; $display("FAIL pm_to_partida got=%b exp=1", mif.partida_tx); end
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (mif.pronto_tx === 1'b1) begin ok = 1'b1; break; end
      tick();
    end
    tick();
    tick();
    checks++;
    if (!ok || mif.partida_tx !== 1'b1) begin errors++; $display("FAIL ptx_to_partida got=%b exp=1", mif.partida_tx); end
    wait_state(4'd7, -1, 500, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL frame_reach_7 got=%0d exp=7", mif.db_estado); end
    checks++;
    if (n_tx - tx0 !== 4) begin errors++; $display("FAIL frame_partida_count got=%0d exp=4", n_tx - tx0); end
    checks++;
    if (n_cp - cp0 !== 4) begin errors++; $display("FAIL frame_conta_count got=%0d exp=4", n_cp - cp0); end
    checks++;
    if (mif.conta_time !== 1'b1) begin errors++; $display("FAIL interval_conta_time got=%b exp=1", mif.conta_time); end
  endtask

  task automatic test_timeout();
    int t_last, tmo0, gap, tx0;
    bit ok;
    pm_auto = 1'b0;
    tmo0 = n_tmo;
    mif.fim_time = 1'b1;
    tick();
    mif.fim_time = 1'b0;
    t_last = cyc;
    for (int r = 0; r < 3; r++) begin
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
        tick();
        if (mif.mensurar === 1'b1) begin ok = 1'b1; break; end
      end
      gap = cyc - t_last;
      checks++;
      if (!ok || gap != 102) begin errors++; $display("FAIL retry%0d_period got=%0d exp=102", r, gap); end
      checks++;
      if (mif.db_timeout !== 1'b1) begin errors++; $display("FAIL retry%0d_db_timeout got=%b exp=1", r, mif.db_timeout); end
      t_last = cyc;
      if (r == 1) pm_auto = 1'b1;
    end
    checks++;
    if (n_tmo - tmo0 !== 3) begin errors++; $display("FAIL timeout_pulses got=%0d exp=3", n_tmo - tmo0); end
    tx0 = n_tx;
    wait_state(4'd7, -1, 500, ok);
    checks++;
    if (!ok || n_tx - tx0 !== 4) begin errors++; $display("FAIL post_timeout_frame got=%0d exp=4", n_tx - tx0); end
  endtask

  task automatic test_hold_mid_frame();
    int tx0;
    bit ok;
    mif.fim_time = 1'b1;
    tick();
    mif.fim_time = 1'b0;
    tx0 = n_tx;
    wait_state(4'd5, 1, 500, ok);
    mif.fim_3sec = 1'b1;
    tick();
    mif.fim_3sec = 1'b0;
    wait_state(4'd7, -1, 500, ok);
    checks++;
    if (!ok || n_tx - tx0 !== 4) begin errors++; $display("FAIL hold_frame_complete got=%0d exp=4", n_tx - tx0); end
    tick();
    checks++;
    if (mif.db_estado !== 4'd8 || mif.pronto !== 1'b1) begin
      errors++; $display("FAIL hold_acertou got=state%0d pronto=%b exp=state8 pronto=1", mif.db_estado, mif.pronto);
    end
  endtask

  task automatic test_priority();
    int m0;
    bit ok;
    mif.iniciar = 1'b1;
    tick();
    mif.iniciar = 1'b0;
    wait_state(4'd3, -1, 20, ok);
    mif.fim_3sec = 1'b1;
    tick();
    mif.fim_3sec = 1'b0;
    wait_state(4'd6, 3, 500, ok);
    mif.fim_time = 1'b1;
    tick();
    checks++;
    if (!ok || mif.db_estado !== 4'd7) begin errors++; $display("FAIL prio_reach_7 got=%0d exp=7", mif.db_estado); end
    m0 = n_mens;
    tick();
    mif.fim_time = 1'b0;
    checks++;
    if (mif.db_estado !== 4'd8 || n_mens != m0) begin
      errors++; $display("FAIL prio_acerto_over_fim_time got=state%0d mens=%0d exp=state8 mens=0", mif.db_estado, n_mens - m0);
    end
  endtask

  task automatic test_clear_wins();
    bit ok;
    mif.iniciar = 1'b1;
    tick();
    mif.iniciar = 1'b0;
    mif.fim_3sec = 1'b1;
    tick();
    mif.fim_3sec = 1'b0;
    checks++;
    if (mif.db_estado !== 4'd2) begin errors++; $display("FAIL restart_medir got=%0d exp=2", mif.db_estado); end
    wait_state(4'd6, 3, 500, ok);
    mif.fim_time = 1'b1;
    tick();
    tick();
    mif.fim_time = 1'b0;
    checks++;
    if (!ok || mif.db_estado !== 4'd2 || mif.mensurar !== 1'b1) begin
      errors++; $display("FAIL acerto_cleared got=state%0d exp=state2", mif.db_estado);
    end
  endtask

  task automatic test_reset_mid_frame();
    int tx0;
    bit ok;
    wait_state(4'd4, 1, 500, ok);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (!ok || mif.db_estado !== 4'd0 || outs() !== 9'b0) begin
      errors++; $display("FAIL midframe_reset got=state%0d/%b exp=state0/all0", mif.db_estado, outs());
    end
    tx0 = n_tx;
    mif.iniciar = 1'b1;
    tick();
    mif.iniciar = 1'b0;
    checks++;
    if (mif.db_estado !== 4'd1 || mif.zera !== 1'b1 || mif.zera_char !== 1'b1) begin
      errors++; $display("FAIL rerun_zera got=state%0d zera=%b zc=%b exp=state1 1 1", mif.db_estado, mif.zera, mif.zera_char);
    end
    wait_state(4'd4, -1, 200, ok);
    checks++;
    if (!ok || cnt !== 2'd0) begin errors++; $display("FAIL rerun_char0 got=%0d exp=0", cnt); end
    wait_state(4'd7, -1, 500, ok);
    checks++;
    if (!ok || n_tx - tx0 !== 4) begin errors++; $display("FAIL rerun_frame got=%0d exp=4", n_tx - tx0); end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_timeout();
    test_hold_mid_frame();
    test_priority();
    test_clear_wins();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
